// File: rtl/timer_apb_regs.sv
// timer_apb_regs
//   APB3 responder and register file for the 8-bit timer.
//   It decodes APB transfers and holds the TDR, TCR and TSR registers.
//   The static TCR control fields drive the counter core directly.
//   Overflow and underflow pulses from the core are caught in sticky TSR bits.
//   The live counter value from the core can be read back at TCNT.
//
//   Register map (byte addresses):
//     0x00 TDR   rw  reload value
//     0x01 TCR   rw  [7] load, [5] down, [4] en, [1:0] cks; other bits read 0
//     0x02 TSR   [0] OVF, [1] UDF; a written 0 clears a bit, a written 1 keeps it
//     0x03 TCNT  ro  live counter value; a write returns pslverr
//     >0x03      pslverr, reads 0x00, writes discarded
//
// Parameters
//   WAIT_CYCLES  wait states added to every access phase (0..3)
//
// Ports
//   pclk, presetn          clock; asynchronous active-low reset
//   psel, penable, pwrite  APB control
//   paddr, pwdata          APB byte address and write data
//   prdata, pready,        APB read data, completion and error response
//   pslverr
//   tdr_o                  reload value to the core
//   load_o, down_o, en_o,  TCR control fields to the core
//   cks_o
//   ovf_set_i, udf_set_i   single-cycle status pulses from the core
//   tcnt_i                 live counter value from the core
module timer_apb_regs #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] tdr_o,
  output logic       load_o,
  output logic       down_o,
  output logic       en_o,
  output logic [1:0] cks_o,
  input  logic       ovf_set_i,
  input  logic       udf_set_i,
  input  logic [7:0] tcnt_i
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  // The bus phase of the current cycle is `state`.
  // It is decoded from psel/penable together with the registered history in
  // `state_q`. A purely registered phase would lag the bus by one cycle.
  // That lag would make every transfer one pclk longer than 2 + WAIT_CYCLES.
  state_t     state_q;
  state_t     state;
  state_t     state_d;
  logic [1:0] wait_cnt;

  logic [7:0] tdr;
  logic       tcr_load;
  logic       tcr_down;
  logic       tcr_en;
  logic [1:0] tcr_cks;
  logic       tsr_ovf;
  logic       tsr_udf;

  logic       addr_err;
  logic       wr_commit;
  logic       wr_tdr;
  logic       wr_tcr;
  logic       wr_tsr;

  // State register and wait-state counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state == SETUP) begin
        wait_cnt <= 2'(WAIT_CYCLES);
      end else if (state == ACCESS && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  // Next-state logic.
  // A cycle is an access phase only if it follows a setup cycle or an
  // unfinished access cycle.
  // penable with no setup before it is ignored.
  // A finished access records IDLE in state_q.
  // After that, only a new setup can start the next transfer.
  always_comb begin
    state = IDLE;
    if (psel) begin
      if (!penable) begin
        state = SETUP;
      end else if (state_q == SETUP || state_q == ACCESS) begin
        state = ACCESS;
      end
    end
    state_d = state;
    if (state == ACCESS && wait_cnt == 2'd0) begin
      state_d = IDLE;
    end
  end

  // Output logic: response, read mux and write decode.
  always_comb begin
    pready    = (state == ACCESS) && (wait_cnt == 2'd0);
    addr_err  = (paddr > 8'h03) || (pwrite && paddr == 8'h03);
    pslverr   = pready && addr_err;
    wr_commit = pready && pwrite && !addr_err;
    wr_tdr    = wr_commit && (paddr == 8'h00);
    wr_tcr    = wr_commit && (paddr == 8'h01);
    wr_tsr    = wr_commit && (paddr == 8'h02);
    prdata    = '0;
    if (pready && !pwrite) begin
      unique case (paddr)
        8'h00:   prdata = tdr;
        8'h01:   prdata = {tcr_load, 1'b0, tcr_down, tcr_en, 2'b00, tcr_cks};
        8'h02:   prdata = {6'b0, tsr_udf, tsr_ovf};
        8'h03:   prdata = tcnt_i;
        default: prdata = '0;
      endcase
    end
  end

  // TDR and TCR.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr      <= '0;
      tcr_load <= 1'b0;
      tcr_down <= 1'b0;
      tcr_en   <= 1'b0;
      tcr_cks  <= '0;
    end else begin
      if (wr_tdr) begin
        tdr <= pwdata;
      end
      if (wr_tcr) begin
        tcr_load <= pwdata[7];
        tcr_down <= pwdata[5];
        tcr_en   <= pwdata[4];
        tcr_cks  <= pwdata[1:0];
      end
    end
  end

  // TSR sticky bits.
  // The set term is ORed in last.
  // A core event therefore wins over a software clear in the same cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tsr_ovf <= 1'b0;
      tsr_udf <= 1'b0;
    end else begin
      tsr_ovf <= ovf_set_i | (tsr_ovf & ~(wr_tsr & ~pwdata[0]));
      tsr_udf <= udf_set_i | (tsr_udf & ~(wr_tsr & ~pwdata[1]));
    end
  end

  assign tdr_o  = tdr;
  assign load_o = tcr_load;
  assign down_o = tcr_down;
  assign en_o   = tcr_en;
  assign cks_o  = tcr_cks;

endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs
//   Bench for timer_apb_regs.
//   There are three instances, with WAIT_CYCLES = 0, 2 and 3.
//   All instances share one bus, and each instance has its own psel.
//   The bench keeps a register-level model of each instance.
//   The model is updated when a transfer completes or a core event arrives.
//   One process compares the core outputs and the idle bus response of every
//   instance against the model on each falling edge.
//   The transfer task checks the response of the selected instance.
//   Literal expectations pin the model on the main scenarios.
module tb_timer_apb_regs;

  logic       pclk;
  logic       presetn;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] tcnt;
  logic       ovf_set;
  logic       udf_set;

  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];
  logic [7:0] tdr_o   [3];
  logic       load_o  [3];
  logic       down_o  [3];
  logic       en_o    [3];
  logic [1:0] cks_o   [3];

  int checks   = 0;
  int failures = 0;

  // Model state per instance; m_tcr holds only the implemented bits.
  logic [7:0] m_tdr [3];
  logic [7:0] m_tcr [3];
  logic [1:0] m_tsr [3];

  logic [7:0] rd;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      timer_apb_regs #(.WAIT_CYCLES(g == 0 ? 0 : g + 1)) u_dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel[g]),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata[g]),
        .pready    (pready[g]),
        .pslverr   (pslverr[g]),
        .tdr_o     (tdr_o[g]),
        .load_o    (load_o[g]),
        .down_o    (down_o[g]),
        .en_o      (en_o[g]),
        .cks_o     (cks_o[g]),
        .ovf_set_i (ovf_set),
        .udf_set_i (udf_set),
        .tcnt_i    (tcnt)
      );
    end
  endgenerate

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int g, input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr[g];
      8'h01:   return m_tcr[g];
      8'h02:   return {6'b0, m_tsr[g]};
      8'h03:   return tcnt;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_tdr[k] = 8'h00;
      m_tcr[k] = 8'h00;
      m_tsr[k] = 2'b00;
    end
  endtask

  // Per-cycle comparison of everything the model determines.
  always @(negedge pclk) begin
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("tdr_o[%0d]", g), tdr_o[g], m_tdr[g]);
      chk($sformatf("ctrl[%0d]", g),
          {3'b0, load_o[g], down_o[g], en_o[g], cks_o[g]},
          {3'b0, m_tcr[g][7], m_tcr[g][5], m_tcr[g][4], m_tcr[g][1:0]});
      if (!psel[g]) begin
        chk($sformatf("idle_resp[%0d]", g), {6'b0, pready[g], pslverr[g]}, 8'h00);
        chk($sformatf("idle_prdata[%0d]", g), prdata[g], 8'h00);
      end
    end
  end

  // One complete transfer.
  // The task starts and ends 1 time unit after a rising edge.
  // Back-to-back calls therefore have no idle cycle between them.
  // evt = {udf, ovf} is pulsed in the last access cycle.
  task automatic xfer(input int g, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] evt,
                      output logic [7:0] rdv);
    int   w;
    bit   err;
    logic [7:0] exp;
    w   = (g == 0) ? 0 : g + 1;
    err = (a > 8'h03) || (wr && a == 8'h03);
    psel[g] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    chk($sformatf("setup_pready[%0d]", g), {7'b0, pready[g]}, 8'h00);
    @(posedge pclk); #1;
    penable = 1'b1;
    if (w == 0) {udf_set, ovf_set} = evt;
    for (int i = 0; i <= w; i++) begin
      @(negedge pclk);
      chk($sformatf("pready[%0d] acc%0d", g, i), {7'b0, pready[g]}, {7'b0, i == w});
      if (i == w) begin
        exp = wr ? 8'h00 : model_rd(g, a);
        chk($sformatf("prdata[%0d] a=%02h", g, a), prdata[g], exp);
        chk($sformatf("pslverr[%0d] a=%02h", g, a), {7'b0, pslverr[g]}, {7'b0, err});
        rdv = prdata[g];
      end else begin
        @(posedge pclk); #1;
        if (i + 1 == w) {udf_set, ovf_set} = evt;
      end
    end
    @(posedge pclk); #1;
    psel[g] = 1'b0; penable = 1'b0; {udf_set, ovf_set} = 2'b00;
    if (wr && !err) begin
      case (a)
        8'h00: m_tdr[g] = d;
        8'h01: m_tcr[g] = d & 8'hB3;
        8'h02: m_tsr[g] = m_tsr[g] & d[1:0];
        default: ;
      endcase
    end
    for (int k = 0; k < 3; k++) m_tsr[k] = m_tsr[k] | evt;
  endtask

  task automatic pulse(input logic [1:0] evt);
    {udf_set, ovf_set} = evt;
    @(posedge pclk); #1;
    {udf_set, ovf_set} = 2'b00;
    for (int k = 0; k < 3; k++) m_tsr[k] = m_tsr[k] | evt;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lit [4];
    lit = '{8'h00, 8'h00, 8'h00, 8'h5A};
    presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tcnt = 8'h5A; ovf_set = 1'b0; udf_set = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    idle(1);

    // Reset values and TCNT read-back.
    for (int a = 0; a < 4; a++) begin
      xfer(0, 1'b0, 8'(a), 8'h00, 2'b00, rd);
      chk($sformatf("lit_reset_read a=%0d", a), rd, lit[a]);
    end

    // TCR fields.
    xfer(0, 1'b1, 8'h01, 8'h11, 2'b00, rd);
    @(negedge pclk);
    chk("lit_tcr11_ctrl", {3'b0, load_o[0], down_o[0], en_o[0], cks_o[0]}, 8'h05);
    @(posedge pclk); #1;
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00, rd);
    chk("lit_tcr11_read", rd, 8'h11);
    xfer(0, 1'b1, 8'h01, 8'hFF, 2'b00, rd);
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00, rd);
    chk("lit_tcrFF_read", rd, 8'hB3);
    idle(3);
    @(negedge pclk);
    chk("lit_load_held", {7'b0, load_o[0]}, 8'h01);
    @(posedge pclk); #1;
    xfer(0, 1'b1, 8'h01, 8'h00, 2'b00, rd);

    // TSR set, clear and set/clear collision.
    pulse(2'b01);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_ovf", rd, 8'h01);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b00, rd);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_clr", rd, 8'h00);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b01, rd);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_collision", rd, 8'h01);
    pulse(2'b10);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_both", rd, 8'h03);
    xfer(0, 1'b1, 8'h02, 8'h02, 2'b00, rd);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_clr_ovf_only", rd, 8'h02);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b00, rd);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b01, rd);
    chk("lit_tsr_read_during_evt", rd, 8'h00);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd);
    chk("lit_tsr_evt_kept", rd, 8'h01);

    // Wait states: WAIT_CYCLES=2, TDR write then back-to-back read.
    xfer(1, 1'b1, 8'h00, 8'hC8, 2'b00, rd);
    @(negedge pclk);
    chk("lit_tdr_c8_visible", tdr_o[1], 8'hC8);
    @(posedge pclk); #1;
    xfer(1, 1'b1, 8'h01, 8'h31, 2'b00, rd);
    xfer(1, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_tdr_c8_read", rd, 8'hC8);

    // Error responses.
    xfer(0, 1'b1, 8'h10, 8'hAA, 2'b00, rd);
    xfer(0, 1'b1, 8'h03, 8'h77, 2'b00, rd);
    xfer(0, 1'b0, 8'h10, 8'h00, 2'b00, rd);
    chk("lit_bad_addr_read", rd, 8'h00);
    xfer(0, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_tdr_untouched", rd, 8'h00);

    // psel dropped in ACCESS before pready (WAIT_CYCLES=2).
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_pready", {7'b0, pready[1]}, 8'h00);
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    idle(2);
    xfer(1, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_abort_no_write", rd, 8'hC8);

    // penable without a setup phase.
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      chk("nosetup_pready", {7'b0, pready[0]}, 8'h00);
      @(posedge pclk); #1;
    end
    psel[0] = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_nosetup_no_write", rd, 8'h00);

    // WAIT_CYCLES=3: configure, then reset in the middle of a transfer.
    tcnt = 8'hA5;
    xfer(2, 1'b1, 8'h00, 8'h3C, 2'b00, rd);
    xfer(2, 1'b1, 8'h01, 8'h91, 2'b00, rd);
    xfer(2, 1'b0, 8'h03, 8'h00, 2'b00, rd);
    chk("lit_tcnt_a5", rd, 8'hA5);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("rst_pre_pready", {7'b0, pready[2]}, 8'h00);
    #1 presetn = 1'b0;
    model_reset();
    #1;
    chk("lit_rst_tdr", tdr_o[2], 8'h00);
    chk("lit_rst_ctrl", {3'b0, load_o[2], down_o[2], en_o[2], cks_o[2]}, 8'h00);
    chk("lit_rst_resp", {6'b0, pready[2], pslverr[2]}, 8'h00);
    chk("lit_rst_prdata", prdata[2], 8'h00);
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);
    xfer(2, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_rst_no_write", rd, 8'h00);
    xfer(1, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_rst_other_inst", rd, 8'h00);
    xfer(2, 1'b1, 8'h00, 8'h96, 2'b00, rd);
    xfer(2, 1'b0, 8'h00, 8'h00, 2'b00, rd);
    chk("lit_post_rst_write", rd, 8'h96);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
